fsk2_rx: RTL

//  2FSK demodulator: the stage directly downstream of fsk2_tx.

---
 rtl/fsk2_rx.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/fsk2_rx.sv
// 2FSK demodulator: slices each symbol period of the DDS sample stream, counts
// hysteretic zero crossings and decides mark/space against a crossing threshold.
module fsk2_rx #(
  parameter int unsigned SYM_LEN   = 1000,
  parameter int unsigned BITS      = 16,
  parameter logic [15:0] MIDSCALE  = 16'd32768,
  parameter logic [15:0] HYST      = 16'd512,
  parameter logic [7:0]  ZC_THRESH = 8'd20
) (
  input  logic            sys_clk,
  input  logic            sys_rst_n,
  input  logic            rx_flag,
  input  logic [15:0]     rx_in,
  output logic [BITS-1:0] data_out,
  output logic            data_valid,
  output logic            busy,
  output logic            frame_err
);

  localparam int unsigned SW = $clog2(SYM_LEN);
  localparam int unsigned BW = $clog2(BITS) + 1;
  localparam logic [SW-1:0] SymLast = SW'(SYM_LEN - 1);
  localparam logic [BW-1:0] BitLast = BW'(BITS - 1);

  // Band edges computed at 17 bits and clamped to the 16-bit sample range.
  localparam logic [16:0] HiSum  = {1'b0, MIDSCALE} + {1'b0, HYST};
  localparam logic [16:0] LoDiff = {1'b0, MIDSCALE} - {1'b0, HYST};
  localparam logic [15:0] HiThr  = HiSum[16] ? 16'hFFFF : HiSum[15:0];
  localparam logic [15:0] LoThr  = LoDiff[16] ? 16'h0000 : LoDiff[15:0];

  typedef enum logic [0:0] {StIdle, StRecv} state_e;

  state_e          state_q, state_d;
  logic            flag_q;
  logic [SW-1:0]   sample_cnt_q, sample_cnt_d;
  logic [BW-1:0]   bit_idx_q, bit_idx_d;
  logic [7:0]      zc_q, zc_d;
  logic            sgn_q, sgn_d;
  logic [BITS-1:0] shreg_q, shreg_d;
  logic [BITS-1:0] data_out_q, data_out_d;
  logic            data_valid_q, data_valid_d;
  logic            frame_err_q, frame_err_d;

  logic       rise;
  logic       sgn_new;
  logic       crossing;
  logic [7:0] zc_inc;
  logic       sym_bit;
  logic       sym_end;
  logic       last_bit;

  assign rise     = rx_flag & ~flag_q;
  assign crossing = sgn_new ^ sgn_q;
  assign zc_inc   = (zc_q == 8'hFF) ? zc_q : zc_q + {7'd0, crossing};
  assign sym_bit  = zc_inc >= ZC_THRESH;
  assign sym_end  = sample_cnt_q == SymLast;
  assign last_bit = bit_idx_q == BitLast;

  always_comb begin
    sgn_new = sgn_q;
    if (rx_in >= HiThr) begin
      sgn_new = 1'b1;
    end else if (rx_in < LoThr) begin
      sgn_new = 1'b0;
    end
  end

  always_comb begin
    state_d      = state_q;
    sample_cnt_d = sample_cnt_q;
    bit_idx_d    = bit_idx_q;
    zc_d         = zc_q;
    sgn_d        = sgn_q;
    shreg_d      = shreg_q;
    data_out_d   = data_out_q;
    data_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    busy         = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (rise) begin
          // The rise cycle is already sample 0 of bit 0.
          busy         = 1'b1;
          state_d      = StRecv;
          sample_cnt_d = SW'(1);
          bit_idx_d    = '0;
          zc_d         = '0;
          sgn_d        = sgn_new;
        end
      end
      StRecv: begin
        busy = 1'b1;
        // A strobe drop on the final decision cycle still delivers the word.
        if (!rx_flag && !(sym_end && last_bit)) begin
          frame_err_d = 1'b1;
          state_d     = StIdle;
        end else begin
          sgn_d        = sgn_new;
          zc_d         = zc_inc;
          sample_cnt_d = sample_cnt_q + SW'(1);
          if (sym_end) begin
            shreg_d      = {shreg_q[BITS-2:0], sym_bit};
            zc_d         = '0;
            sample_cnt_d = '0;
            bit_idx_d    = bit_idx_q + BW'(1);
            if (last_bit) begin
              data_out_d   = {shreg_q[BITS-2:0], sym_bit};
              data_valid_d = 1'b1;
              state_d      = StIdle;
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // flag_q resets high so a strobe already high at reset release is not a frame start.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q      <= StIdle;
      flag_q       <= 1'b1;
      sample_cnt_q <= '0;
      bit_idx_q    <= '0;
      zc_q         <= '0;
      sgn_q        <= 1'b0;
      shreg_q      <= '0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      flag_q       <= rx_flag;
      sample_cnt_q <= sample_cnt_d;
      bit_idx_q    <= bit_idx_d;
      zc_q         <= zc_d;
      sgn_q        <= sgn_d;
      shreg_q      <= shreg_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign frame_err  = frame_err_q;

endmodule
